// File: rtl/switch_sched_pkg.sv
// Shared types and width helpers for the switch scheduler: top FSM states,
// ramp direction and index widths derived from the channel/event counts.
package switch_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RAMP_HOLD = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } ramp_dir_e;

  // Select widths never drop to zero, so a single channel/slot still gets a 1-bit port.
  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int idx_w(input int nev);
    return (nev > 1) ? $clog2(nev) : 1;
  endfunction

  // The event pointer must be able to hold NEV itself (end of table).
  function automatic int ptr_w(input int nev);
    return $clog2(nev + 1);
  endfunction

endpackage

// File: rtl/switch_sched_chan.sv
// One switch channel: event table, event pointer, switch state, transition
// ramp and the sticky overlap flag.
module switch_sched_chan
  import switch_sched_pkg::*;
#(
  parameter int NEV = 4,
  parameter int TW  = 16,
  parameter int RW  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [idx_w(NEV)-1:0] wr_idx_i,
  input  logic [TW-1:0]         wr_time_i,
  input  logic                  load_i,
  input  logic                  init_on_i,
  input  logic                  run_en_i,
  input  logic [TW-1:0]         tb_i,
  output logic                  sw_on_o,
  output logic [RW-1:0]         ramp_o,
  output logic                  exhausted_o,
  output logic                  at_target_o,
  output logic                  fire_o,
  output logic                  err_overlap_o
);

  localparam int IW = idx_w(NEV);
  localparam int PW = ptr_w(NEV);

  logic [TW-1:0] tab_q [NEV];
  logic [PW-1:0] ptr_q;
  logic          sw_on_q;
  logic          err_q;
  logic [RW-1:0] ramp_q;
  logic [RW-1:0] ramp_d;
  logic [RW-1:0] cur_target;
  logic [RW-1:0] next_target;
  logic [TW-1:0] cur_time;
  logic          next_on;
  logic          exhausted;
  logic          fire;
  ramp_dir_e     dir;

  // A pointer past the last slot reads as an empty entry, which ends the list.
  always_comb begin
    cur_time = '0;
    for (int i = 0; i < NEV; i++) begin
      if (ptr_q == PW'(i)) cur_time = tab_q[i];
    end
  end

  assign exhausted   = (cur_time == '0);
  assign fire        = run_en_i && !exhausted && (tb_i == cur_time);
  assign cur_target  = sw_on_q ? '1 : '0;
  assign next_on     = sw_on_q ^ fire;
  assign next_target = next_on ? '1 : '0;

  // The ramp heads for the post-event target in the same cycle the event fires,
  // so a reversal continues from the current code without a jump.
  always_comb begin
    dir = RAMP_HOLD;
    if (ramp_q != next_target) dir = next_on ? RAMP_UP : RAMP_DOWN;
    case (dir)
      RAMP_UP:   ramp_d = ramp_q + RW'(1);
      RAMP_DOWN: ramp_d = ramp_q - RW'(1);
      default:   ramp_d = ramp_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NEV; i++) tab_q[i] <= '0;
      ptr_q   <= '0;
      sw_on_q <= 1'b0;
      ramp_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NEV; i++) begin
        if (wr_en_i && (wr_idx_i == IW'(i))) tab_q[i] <= wr_time_i;
      end
      if (load_i) begin
        sw_on_q <= init_on_i;
        ramp_q  <= init_on_i ? '1 : '0;
        ptr_q   <= '0;
        err_q   <= 1'b0;
      end else if (run_en_i) begin
        sw_on_q <= next_on;
        ramp_q  <= ramp_d;
        if (fire) begin
          ptr_q <= ptr_q + PW'(1);
          if (ramp_q != cur_target) err_q <= 1'b1;
        end
      end
    end
  end

  assign sw_on_o       = sw_on_q;
  assign ramp_o        = ramp_q;
  assign exhausted_o   = exhausted;
  assign at_target_o   = (ramp_q == cur_target);
  assign fire_o        = fire;
  assign err_overlap_o = err_q;

endmodule

// File: rtl/switch_sched.sv
// Timed switch scheduler: a shared timebase drives NCH channels that toggle on
// programmed event times and ramp their control code between off and on.
module switch_sched
  import switch_sched_pkg::*;
#(
  parameter int NCH = 4,
  parameter int NEV = 4,
  parameter int TW  = 16,
  parameter int RW  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [ch_w(NCH)-1:0]  cfg_ch,
  input  logic [idx_w(NEV)-1:0] cfg_idx,
  input  logic [TW-1:0]         cfg_time,
  input  logic [NCH-1:0]        init,
  input  logic                  start,
  input  logic                  abort,
  output logic [NCH-1:0]        sw_on,
  output logic [NCH*RW-1:0]     ramp,
  output logic                  busy,
  output logic                  done,
  output logic [NCH-1:0]        err_overlap
);

  localparam int CW = ch_w(NCH);

  state_e        state_q;
  logic [TW-1:0] tb_q;
  logic          busy_q;
  logic          done_q;

  logic          tb_sat;
  logic          load;
  logic          run_en;
  logic          finish_ok;
  logic [NCH-1:0] wr_en;
  logic [NCH-1:0] exhausted;
  logic [NCH-1:0] at_target;
  logic [NCH-1:0] fire;
  logic [RW-1:0]  ramp_w [NCH];

  assign tb_sat = &tb_q;
  assign load   = start && (state_q == ST_IDLE);
  // Abort suppresses any event due in the same cycle.
  assign run_en = (state_q == ST_RUN) && !abort;

  // A cycle in which some channel fires is never the last one: its ramp just left its target.
  assign finish_ok = (&(exhausted | {NCH{tb_sat}})) && (&at_target) && !(|fire);

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    assign wr_en[c] = cfg_we && (cfg_ch == CW'(c));

    switch_sched_chan #(
      .NEV (NEV),
      .TW  (TW),
      .RW  (RW)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_en_i       (wr_en[c]),
      .wr_idx_i      (cfg_idx),
      .wr_time_i     (cfg_time),
      .load_i        (load),
      .init_on_i     (init[c]),
      .run_en_i      (run_en),
      .tb_i          (tb_q),
      .sw_on_o       (sw_on[c]),
      .ramp_o        (ramp_w[c]),
      .exhausted_o   (exhausted[c]),
      .at_target_o   (at_target[c]),
      .fire_o        (fire[c]),
      .err_overlap_o (err_overlap[c])
    );

    assign ramp[c*RW +: RW] = ramp_w[c];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tb_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            tb_q    <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            if (!tb_sat) tb_q <= tb_q + TW'(1);
            if (finish_ok) begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
            end
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: doc/switch_sched.md
SWITCH_SCHED -- requirements
Module: switch_sched

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent switch channels (1..16).
REQ-002 SHALL have parameter NEV, default 4: toggle events per channel (1..8).
REQ-003 SHALL have parameter TW, default 16: width of the timebase and event times, in ticks.
REQ-004 SHALL have parameter RW, default 4: width of the transition ramp; full ramp length is 2^RW-1 cycles.
REQ-005 SHALL have one clock; reset is asynchronous and active-low. Ports: clk and rst_n.
REQ-006 SHALL have ports, listed as name / direction / width / meaning:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  write one event-table entry.
- cfg_ch  in  clog2(NCH)  channel select for cfg_we.
- cfg_idx  in  clog2(NEV)  event slot select for cfg_we.
- cfg_time  in  TW  event time in ticks; 0 means unused / end of list.
- init  in  NCH  per-channel initial state, 1 = on.
- start  in  1  single-cycle pulse that begins a run.
- abort  in  1  single-cycle pulse that stops a run.
- sw_on  out  NCH  per-channel logical switch state.
- ramp  out  NCH*RW  per-channel control code; 0 = fully off, all-ones = fully on.
- busy  out  1  high while a run is in progress.
- done  out  1  single-cycle pulse when a run completes.
- err_overlap  out  NCH  sticky flag: an event arrived while that channel was ramping.

Function
REQ-007 SHALL implement a top FSM with states IDLE, RUN, FINISH.
REQ-008 IDLE -> RUN on start. On that edge: timebase cleared to 0; each channel's sw_on and ramp loaded from init (ramp all-ones or 0); event pointers cleared; err_overlap cleared.
REQ-009 start SHALL be ignored while busy=1.
REQ-010 In RUN the timebase SHALL increment by 1 per cycle and saturate at 2^TW-1.
REQ-011 A channel event SHALL fire in the cycle where timebase == table[ch][ptr] and the entry is nonzero. On fire: sw_on toggles, ptr increments, ramp begins moving toward the new target.
REQ-012 A zero entry, or ptr == NEV, SHALL mark the channel as exhausted. An exhausted channel produces no further events.
REQ-013 Ramp SHALL step by 1 per cycle toward its target (0 or all-ones) and hold once the target is reached.
REQ-014 An event firing while the channel's ramp is still moving SHALL:
- set err_overlap[ch];
- toggle sw_on;
- reverse the ramp direction from its current value, with no jump.
REQ-015 Event tables SHALL hold ascending times. Non-ascending entries are not detected; an entry already passed never fires, and the channel stalls at that pointer until the run ends.
REQ-016 RUN -> FINISH when, in the same cycle:
- every channel is exhausted, or the timebase is saturated; and
- every ramp is at its target.
REQ-017 FINISH SHALL assert done for exactly one cycle and then go to IDLE.
REQ-018 busy SHALL be high in RUN and FINISH.
REQ-019 sw_on and ramp SHALL hold their values in IDLE after a run.
REQ-020 abort in RUN SHALL:
- move the FSM to IDLE on the next edge, with no done pulse;
- freeze sw_on and ramp at their current values.
REQ-021 If cfg_we occurs while busy, the write is applied to the table immediately; an event slot written after its time has passed does not fire.
REQ-022 If an event fires in the same cycle as abort, abort wins and the event is not applied.
REQ-023 Channels sharing an event time SHALL fire in the same cycle, independently of each other.

Reset
REQ-024 rst_n low SHALL asynchronously set: FSM IDLE; timebase 0; sw_on 0; ramp 0; busy 0; done 0; err_overlap 0; all pointers 0; all event table entries 0.
REQ-025 Reset asserted mid-run SHALL discard the run; no done pulse is produced after reset release.

Structure
REQ-026 A shared package SHALL hold the FSM state enum, the ramp-direction type, and the width helpers for clog2(NCH) and clog2(NEV).
REQ-027 The per-channel logic (pointer, event compare, sw_on, ramp, overlap flag) SHALL be one sub-module, switch_sched_chan, instantiated NCH times. The top level holds the FSM, the timebase and the config decode.

Verification (defaults NCH=4, NEV=4, TW=16, RW=4)
REQ-028 ch0 table {10,40,0,0}, init=0, start -> sw_on[0] rises at tick 10; ramp[0] reaches 15 by tick 25; sw_on[0] falls at tick 40; ramp[0] reaches 0 by tick 55; done pulses once; err_overlap=0.
REQ-029 ch1 table {10,15}, init=0 -> at tick 15 ramp[1]=5, direction reverses and ramp[1] reaches 0 at tick 20; err_overlap[1]=1.
REQ-030 All channels table {20}, init=4'b1010 -> all four toggle in the same cycle; sw_on=4'b0101 after tick 20.
REQ-031 abort at tick 12 with ch0 table {10} -> busy falls; no done pulse; sw_on[0]=1; ramp[0] frozen at 2.
REQ-032 rst_n pulsed low mid-run -> all outputs 0 immediately; start then gives a clean run, with done only when every channel table is empty (immediate FINISH at tick 0).
REQ-033 TW=4, ch0 table {15} -> timebase saturates at 15; event fires; done pulses after the ramp settles.
